// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel 3x3 window feed controller.
// Revision: 1.0
`default_nettype none

package sobel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL0  = 2'd1,
    ST_FILL1  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam int DEFAULT_COLS    = 100;
  localparam int DEFAULT_ROWS    = 100;
  localparam int DEFAULT_TIMEOUT = 5_000_000;

endpackage

`default_nettype wire

// File: rtl/sobel_idle_timer.sv
// Idle watchdog: counts enabled cycles since the last clear, pulses expire at TIMEOUT-1.
// Revision: 1.0
`default_nettype none

module sobel_idle_timer
  import sobel_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic sclk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt;

  // Expire ignores clear so that a byte arriving on the abort cycle cannot rescue the frame.
  assign expire = enable && (cnt == CNT_LAST);

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear || !enable || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + TW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sobel_feed_ctrl.sv
// Feeds a 3-row pixel column to a Sobel core from a byte stream using two line FIFOs.
// Revision: 1.0
`default_nettype none

module sobel_feed_ctrl
  import sobel_pkg::*;
#(
  parameter int COLS    = DEFAULT_COLS,
  parameter int ROWS    = DEFAULT_ROWS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       sclk,
  input  logic       rst,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       fifo1_wr_en,
  output logic [7:0] fifo1_wr_data,
  output logic       fifo2_wr_en,
  output logic [7:0] fifo2_wr_data,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo1_q,
  input  logic [7:0] fifo2_q,
  output logic       fifo_clr,
  output logic       po_col_flag,
  output logic [7:0] po_top,
  output logic [7:0] po_mid,
  output logic [7:0] po_bot,
  output logic       frame_done,
  output logic       ovf_err,
  output logic       abort_err
);

  localparam logic [9:0] COL_LAST = 10'(COLS - 1);
  localparam logic [9:0] ROW_LAST = 10'(ROWS - 1);

  state_t     state;
  logic [9:0] col;
  logic [9:0] row;
  logic [1:0] gap;
  logic [7:0] byte_r;
  logic       f1_fill;
  logic       f2_fill;
  logic       rd_en_r;
  logic       wb1;
  logic       wb2;
  logic       done1;
  logic       done2;
  logic       s2;
  logic       clr_r;
  logic       ovf_r;
  logic       abort_r;
  logic [7:0] top_h;
  logic [7:0] mid_h;
  logic [7:0] bot_h;
  logic       expire;
  logic       accept;

  sobel_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .sclk  (sclk),
    .rst   (rst),
    .clear (pi_flag),
    .enable(state != ST_IDLE),
    .expire(expire)
  );

  assign accept = pi_flag && (gap == 2'd0) && !expire;

  // FIFO q only becomes valid in the stage-2 cycle, so the column and write-back
  // data are steered straight from q then and held in registers afterwards.
  assign fifo1_wr_en   = f1_fill | (s2 & wb2);
  assign fifo1_wr_data = s2 ? fifo2_q : byte_r;
  assign fifo2_wr_en   = f2_fill | (s2 & wb2);
  assign fifo2_wr_data = byte_r;
  assign fifo_rd_en    = rd_en_r;
  assign fifo_clr      = clr_r;
  assign po_col_flag   = s2;
  assign po_top        = s2 ? fifo1_q : top_h;
  assign po_mid        = s2 ? fifo2_q : mid_h;
  assign po_bot        = s2 ? byte_r  : bot_h;
  assign frame_done    = done2;
  assign ovf_err       = ovf_r;
  assign abort_err     = abort_r;

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      col     <= '0;
      row     <= '0;
      gap     <= '0;
      byte_r  <= '0;
      f1_fill <= 1'b0;
      f2_fill <= 1'b0;
      rd_en_r <= 1'b0;
      wb1     <= 1'b0;
      wb2     <= 1'b0;
      done1   <= 1'b0;
      done2   <= 1'b0;
      s2      <= 1'b0;
      clr_r   <= 1'b0;
      ovf_r   <= 1'b0;
      abort_r <= 1'b0;
      top_h   <= '0;
      mid_h   <= '0;
      bot_h   <= '0;
    end else begin
      f1_fill <= 1'b0;
      f2_fill <= 1'b0;
      rd_en_r <= 1'b0;
      clr_r   <= 1'b0;
      done1   <= 1'b0;
      s2      <= rd_en_r;
      wb2     <= wb1;
      done2   <= done1;
      if (gap != 2'd0) gap <= gap - 2'd1;
      if (s2) begin
        top_h <= fifo1_q;
        mid_h <= fifo2_q;
        bot_h <= byte_r;
      end

      if (expire) begin
        clr_r   <= 1'b1;
        abort_r <= 1'b1;
        state   <= ST_IDLE;
        col     <= '0;
        row     <= '0;
        gap     <= '0;
      end else if (accept) begin
        byte_r <= pi_data;
        gap    <= 2'd2;
        case (state)
          ST_IDLE, ST_FILL0: f1_fill <= 1'b1;
          ST_FILL1:          f2_fill <= 1'b1;
          default: begin
            rd_en_r <= 1'b1;
            // The final row is never needed again, so it is not written back.
            wb1     <= (row != ROW_LAST);
            done1   <= (row == ROW_LAST) && (col == COL_LAST);
          end
        endcase

        if (col == COL_LAST) begin
          col <= '0;
          case (state)
            ST_IDLE, ST_FILL0: begin
              state <= ST_FILL1;
              row   <= 10'd1;
            end
            ST_FILL1: begin
              state <= ST_STREAM;
              row   <= 10'd2;
            end
            default: begin
              if (row == ROW_LAST) begin
                state <= ST_IDLE;
                row   <= '0;
              end else begin
                row <= row + 10'd1;
              end
            end
          endcase
        end else begin
          col <= col + 10'd1;
          if (state == ST_IDLE) state <= ST_FILL0;
        end
      end else if (pi_flag && (gap != 2'd0)) begin
        ovf_r <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sobel_feed_ctrl.sv
// Directed, table-driven bench for sobel_feed_ctrl with behavioural line FIFOs.
`default_nettype none

module tb_sobel_feed_ctrl;
  import sobel_pkg::*;

  localparam int COLS    = 4;
  localparam int ROWS    = 3;
  localparam int TIMEOUT = 16;

  logic       sclk = 1'b0;
  logic       rst = 1'b1;
  logic       pi_flag = 1'b0;
  logic [7:0] pi_data = 8'd0;
  logic       fifo1_wr_en, fifo2_wr_en, fifo_rd_en, fifo_clr;
  logic [7:0] fifo1_wr_data, fifo2_wr_data;
  logic [7:0] fifo1_q, fifo2_q;
  logic       po_col_flag, frame_done, ovf_err, abort_err;
  logic [7:0] po_top, po_mid, po_bot;

  sobel_feed_ctrl #(.COLS(COLS), .ROWS(ROWS), .TIMEOUT(TIMEOUT)) dut (
    .sclk(sclk), .rst(rst), .pi_flag(pi_flag), .pi_data(pi_data),
    .fifo1_wr_en(fifo1_wr_en), .fifo1_wr_data(fifo1_wr_data),
    .fifo2_wr_en(fifo2_wr_en), .fifo2_wr_data(fifo2_wr_data),
    .fifo_rd_en(fifo_rd_en), .fifo1_q(fifo1_q), .fifo2_q(fifo2_q),
    .fifo_clr(fifo_clr), .po_col_flag(po_col_flag),
    .po_top(po_top), .po_mid(po_mid), .po_bot(po_bot),
    .frame_done(frame_done), .ovf_err(ovf_err), .abort_err(abort_err)
  );

  always #5 sclk = ~sclk;

  int total = 0;
  int bad = 0;

  // Behavioural line FIFOs: registered q, synchronous clear, reset by rst.
  logic [7:0] q1_m[$];
  logic [7:0] q2_m[$];
  int uflow = 0;
  always @(posedge sclk or posedge rst) begin
    if (rst) begin
      q1_m.delete(); q2_m.delete();
      fifo1_q <= 8'd0; fifo2_q <= 8'd0;
    end else if (fifo_clr) begin
      q1_m.delete(); q2_m.delete();
      fifo1_q <= 8'd0; fifo2_q <= 8'd0;
    end else begin
      if (fifo_rd_en) begin
        if (q1_m.size() == 0 || q2_m.size() == 0) uflow++;
        fifo1_q <= (q1_m.size() > 0) ? q1_m.pop_front() : 8'd0;
        fifo2_q <= (q2_m.size() > 0) ? q2_m.pop_front() : 8'd0;
      end
      if (fifo1_wr_en) q1_m.push_back(fifo1_wr_data);
      if (fifo2_wr_en) q2_m.push_back(fifo2_wr_data);
    end
  end

  int n_w1 = 0, n_w2 = 0, n_col = 0, n_done = 0, n_clr = 0, hold_bad = 0;
  logic [7:0] w1d = 0, w2d = 0, ct = 0, cm = 0, cb = 0;
  logic [7:0] ht = 0, hm = 0, hb = 0;
  always @(negedge sclk) begin
    if (fifo1_wr_en) begin n_w1++; w1d = fifo1_wr_data; end
    if (fifo2_wr_en) begin n_w2++; w2d = fifo2_wr_data; end
    if (po_col_flag) begin n_col++; ct = po_top; cm = po_mid; cb = po_bot; end
    if (frame_done) n_done++;
    if (fifo_clr) n_clr++;
    if (rst) begin
      ht = 0; hm = 0; hb = 0;
    end else if (po_col_flag) begin
      ht = po_top; hm = po_mid; hb = po_bot;
    end else if (po_top != ht || po_mid != hm || po_bot != hb) begin
      hold_bad++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {16'd0, fifo1_wr_en, fifo1_wr_data, fifo2_wr_en, fifo2_wr_data, fifo_rd_en,
            fifo_clr, po_col_flag, po_top, po_mid, po_bot, frame_done, ovf_err, abort_err};
  endfunction

  task automatic send_byte(input logic [7:0] d);
    @(posedge sclk); #1;
    pi_flag = 1'b1; pi_data = d;
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    repeat (8) @(posedge sclk);
  endtask

  task automatic reset_dut();
    @(posedge sclk); #1;
    rst = 1'b1;
    repeat (3) @(posedge sclk);
    #1 rst = 1'b0;
    repeat (2) @(posedge sclk);
  endtask

  typedef struct {
    logic [7:0] din;
    bit w1, w2, col, done;
    logic [7:0] top, mid, bot;
  } vec_t;
  vec_t tbl[12];

  function automatic vec_t mk(input logic [7:0] din, input bit w1, input bit w2, input bit col,
                              input bit done, input logic [7:0] t, input logic [7:0] m,
                              input logic [7:0] b);
    vec_t v;
    v.din = din; v.w1 = w1; v.w2 = w2; v.col = col; v.done = done;
    v.top = t; v.mid = m; v.bot = b;
    return v;
  endfunction

  task automatic run_frame(input string tag);
    int a1, a2, ac, ad;
    for (int i = 0; i < 12; i++) begin
      a1 = n_w1; a2 = n_w2; ac = n_col; ad = n_done;
      send_byte(tbl[i].din);
      chk($sformatf("%s w1_cnt[%0d]", tag, i), 64'(n_w1 - a1), 64'(tbl[i].w1));
      if (tbl[i].w1) chk($sformatf("%s w1_data[%0d]", tag, i), 64'(w1d), 64'(tbl[i].din));
      chk($sformatf("%s w2_cnt[%0d]", tag, i), 64'(n_w2 - a2), 64'(tbl[i].w2));
      if (tbl[i].w2) chk($sformatf("%s w2_data[%0d]", tag, i), 64'(w2d), 64'(tbl[i].din));
      chk($sformatf("%s col_cnt[%0d]", tag, i), 64'(n_col - ac), 64'(tbl[i].col));
      if (tbl[i].col)
        chk($sformatf("%s column[%0d]", tag, i), 64'({ct, cm, cb}),
            64'({tbl[i].top, tbl[i].mid, tbl[i].bot}));
      chk($sformatf("%s done_cnt[%0d]", tag, i), 64'(n_done - ad), 64'(tbl[i].done));
    end
    chk({tag, " state_idle"}, 64'(dut.state), 64'(ST_IDLE));
    chk({tag, " fifo_occ"}, 64'(q1_m.size() + q2_m.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, a1;
    tbl[0]  = mk(8'd1,  1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[1]  = mk(8'd2,  1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[2]  = mk(8'd3,  1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[3]  = mk(8'd4,  1, 0, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[4]  = mk(8'd5,  0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[5]  = mk(8'd6,  0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[6]  = mk(8'd7,  0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[7]  = mk(8'd8,  0, 1, 0, 0, 8'd0, 8'd0, 8'd0);
    tbl[8]  = mk(8'd9,  0, 0, 1, 0, 8'd1, 8'd5, 8'd9);
    tbl[9]  = mk(8'd10, 0, 0, 1, 0, 8'd2, 8'd6, 8'd10);
    tbl[10] = mk(8'd11, 0, 0, 1, 0, 8'd3, 8'd7, 8'd11);
    tbl[11] = mk(8'd12, 0, 0, 1, 1, 8'd4, 8'd8, 8'd12);

    // Reset state
    repeat (2) @(posedge sclk);
    #1;
    chk("reset outputs", out_vec(), 64'd0);
    chk("reset state", 64'(dut.state), 64'(ST_IDLE));
    chk("reset col/row", 64'({dut.col, dut.row}), 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge sclk);

    // Single frame, then a back-to-back second frame
    run_frame("frame1");
    chk("frame1 errors", 64'({ovf_err, abort_err}), 64'd0);
    run_frame("frame2");

    // Byte one cycle after an accepted byte is dropped
    a1 = n_w1;
    @(posedge sclk); #1;
    pi_flag = 1'b1; pi_data = 8'hAA;
    @(posedge sclk); #1;
    pi_data = 8'hBB;
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    repeat (5) @(posedge sclk);
    #1;
    chk("ovf w1_cnt", 64'(n_w1 - a1), 64'd1);
    chk("ovf w1_data", 64'(w1d), 64'hAA);
    chk("ovf col", 64'(dut.col), 64'd1);
    chk("ovf flag", 64'(ovf_err), 64'd1);
    chk("ovf state", 64'(dut.state), 64'(ST_FILL0));
    reset_dut();
    chk("ovf cleared by rst", 64'(ovf_err), 64'd0);

    // Timeout abort mid-frame, then recovery
    c0 = n_clr;
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    repeat (30) @(posedge sclk);
    #1;
    chk("abort clr_pulses", 64'(n_clr - c0), 64'd1);
    chk("abort flag", 64'(abort_err), 64'd1);
    chk("abort state", 64'(dut.state), 64'(ST_IDLE));
    chk("abort fifo_occ", 64'(q1_m.size() + q2_m.size()), 64'd0);
    run_frame("after_abort");
    chk("abort sticky", 64'(abort_err), 64'd1);

    // Asynchronous reset in the middle of a frame
    reset_dut();
    for (int i = 0; i < 6; i++) send_byte(8'(i + 1));
    @(posedge sclk); #1;
    pi_flag = 1'b1; pi_data = 8'd7;
    @(posedge sclk); #1;
    pi_flag = 1'b0;
    chk("pre-rst fifo2 write", 64'({fifo2_wr_en, fifo2_wr_data}), 64'({1'b1, 8'd7}));
    #2 rst = 1'b1;
    #1;
    chk("async rst outputs", out_vec(), 64'd0);
    chk("async rst state", 64'(dut.state), 64'(ST_IDLE));
    chk("async rst col/row", 64'({dut.col, dut.row}), 64'd0);
    repeat (2) @(posedge sclk);
    #1 rst = 1'b0;
    repeat (3) @(posedge sclk);
    run_frame("after_rst");

    chk("column hold", 64'(hold_bad), 64'd0);
    chk("fifo underflow", 64'(uflow), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sobel_feed_ctrl.md
SOBEL_FEED_CTRL -- requirements
Module: sobel_feed_ctrl

Interface
REQ-001 Parameter COLS, default 100, pixels per image row; legal range 2..1023.
REQ-002 Parameter ROWS, default 100, rows per frame; legal range 3..1023.
REQ-003 Parameter TIMEOUT, default 5_000_000, sclk cycles without pi_flag mid-frame before abort.
REQ-004 sclk  in  1  the single clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-high.
REQ-006 pi_flag  in  1  one-cycle strobe, received byte valid (from UART receive path po_flag).
REQ-007 pi_data  in  8  received pixel byte, valid when pi_flag=1.
REQ-008 fifo1_wr_en / fifo1_wr_data  out  1 / 8  write port, line FIFO 1 (row n-2).
REQ-009 fifo2_wr_en / fifo2_wr_data  out  1 / 8  write port, line FIFO 2 (row n-1).
REQ-010 fifo_rd_en  out  1  read strobe to both line FIFOs; their q is valid the following cycle.
REQ-011 fifo1_q, fifo2_q  in  8 each  FIFO read data.
REQ-012 fifo_clr  out  1  one-cycle synchronous clear pulse to both FIFOs.
REQ-013 po_col_flag  out  1  one-cycle strobe, 3-pixel vertical column valid.
REQ-014 po_top, po_mid, po_bot  out  8 each  column pixels, rows n-2, n-1, n.
REQ-015 frame_done  out  1  one-cycle pulse after the last column of a frame.
REQ-016 ovf_err, abort_err  out  1 each  sticky error flags.

Function
REQ-017 States: IDLE, FILL0 (row 0), FILL1 (row 1), STREAM (rows 2..ROWS-1).
REQ-018 Counters col (0..COLS-1) and row (0..ROWS-1) advance on each accepted pi_flag; col wraps at COLS-1 and increments row.
REQ-019 IDLE + pi_flag: byte accepted as row 0, col 0; next state FILL0.
REQ-020 FILL0/IDLE byte at cycle t: fifo1_wr_en=1, fifo1_wr_data=byte at t+1.
REQ-021 FILL0 -> FILL1 on acceptance of col COLS-1; FILL1 byte at t: fifo2_wr_en=1, data=byte at t+1.
REQ-022 FILL1 -> STREAM on acceptance of col COLS-1 of row 1.
REQ-023 STREAM byte at t: fifo_rd_en=1 at t+1; at t+2 fifo1_wr_en=1 with fifo2_q, fifo2_wr_en=1 with the held byte, po_col_flag=1, po_top=fifo1_q, po_mid=fifo2_q, po_bot=held byte.
REQ-024 po_top/mid/bot hold their value until the next po_col_flag.
REQ-025 Acceptance of row ROWS-1, col COLS-1: frame_done=1 coincident with its po_col_flag (t+2); counters clear; state IDLE.
REQ-026 Accepted bytes are at least 3 cycles apart; pi_flag at t+1 or t+2 after an accepted byte is dropped (no write, no count) and sets ovf_err.
REQ-027 Idle counter clears on every pi_flag and counts in FILL0, FILL1, STREAM; on reaching TIMEOUT-1: fifo_clr=1 one cycle, abort_err set, counters clear, state IDLE; no counting in IDLE.
REQ-028 pi_flag on the timeout cycle is dropped; the abort wins.
REQ-029 Error flags clear only on rst.

Reset
REQ-030 While rst=1: state IDLE; col, row, idle counter 0; all outputs (including data buses and error flags) 0.
REQ-031 Reset mid-frame discards the partial frame; FIFOs are reset by the same rst; first byte after release is row 0, col 0.

Structure
REQ-032 Shared package sobel_pkg holds the state enumeration and default COLS, ROWS, TIMEOUT constants.
REQ-033 Timeout counter is a sub-module sobel_idle_timer (inputs clear, enable; output expire pulse).
REQ-034 Remaining logic is one module: FSM, col/row counters, 2-stage pipeline registers.

Verification (COLS=4, ROWS=3, TIMEOUT=16, bytes 10 cycles apart unless stated)
REQ-035 Frame bytes 1..12 -> fifo1 writes 1,2,3,4; fifo2 writes 5,6,7,8; four po_col_flags with (top,mid,bot) = (1,5,9),(2,6,10),(3,7,11),(4,8,12); frame_done with the fourth; state IDLE.
REQ-036 Two back-to-back frames -> second frame identical columns; FIFO occupancy 0 after STREAM writes cease on each frame's close.
REQ-037 Byte 0xAA then pi_flag one cycle later with 0xBB -> 0xBB ignored, col=1, ovf_err=1.
REQ-038 Six bytes then 16 silent cycles -> single fifo_clr pulse, abort_err=1, IDLE; next 12 bytes produce a correct frame.
REQ-039 rst pulsed after byte 7 -> all outputs 0 immediately (async); subsequent 12 bytes produce REQ-035 columns.
